// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit stream: frame state encoding and defaults.
package uart_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_START = 2'd1;
    localparam logic [1:0] ENC_DATA  = 2'd2;
    localparam logic [1:0] ENC_STOP  = 2'd3;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 106;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_START = ENC_START,
        ST_DATA  = ENC_DATA,
        ST_STOP  = ENC_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through output, feeding the UART framer.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = UART_DATA_BITS,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q;
    logic          push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_q];
    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_q] <= din;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter fed by a small FIFO; drives an idle-high serial line, LSB first.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
    end

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic             bit_end;

    assign in_ready = ~fifo_full & ~rst;
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) | (fifo_level != '0);
    assign bit_end  = (cnt_q == '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8),
        .LW    (LVL_W)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (in_valid & in_ready),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? CNT_RELOAD : cnt_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    cnt_d    = CNT_RELOAD;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit so queued frames abut.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_RELOAD;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: frame-timeline reference model checked every cycle, plus directed scenarios.
module tb_uart_tx_stream;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       rdy0, tx0, busy0, rdy1, tx1, busy1;
    logic [2:0] lvl0, lvl1;

    always #5 clock = ~clock;

    uart_tx_stream #(.CLKS_PER_BIT(106), .FIFO_DEPTH(DEPTH), .LVL_W(3)) dut (
        .clock(clock), .rst(rst), .in_data(d0), .in_valid(v0),
        .in_ready(rdy0), .tx(tx0), .busy(busy0), .fifo_level(lvl0));

    uart_tx_stream #(.CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH), .LVL_W(3)) dut_fast (
        .clock(clock), .rst(rst), .in_data(d1), .in_valid(v1),
        .in_ready(rdy1), .tx(tx1), .busy(busy1), .fifo_level(lvl1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Reference model: FIFO contents plus position within the current 10-bit frame.
    int         cpb [2] = '{106, 2};
    logic [7:0] mq [2][DEPTH];
    int         mcnt [2] = '{0, 0};
    int         mhead [2] = '{0, 0};
    bit         mact [2] = '{0, 0};
    logic [7:0] mbyte [2];
    int         mt [2] = '{0, 0};
    logic       m_vin;
    logic [7:0] m_din;
    int         m_pre, m_tail;
    bit         m_push, m_pop, m_end;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mcnt[i] = 0; mhead[i] = 0; mact[i] = 0; mt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_vin  = (i == 0) ? v0 : v1;
                m_din  = (i == 0) ? d0 : d1;
                m_pre  = mcnt[i];
                m_tail = (mhead[i] + m_pre) % DEPTH;
                m_push = m_vin && (m_pre < DEPTH);
                m_end  = mact[i] && (mt[i] == 10 * cpb[i] - 1);
                m_pop  = (m_pre > 0) && (!mact[i] || m_end);
                if (m_pop) begin
                    mbyte[i] = mq[i][mhead[i]];
                    mhead[i] = (mhead[i] + 1) % DEPTH;
                    mact[i]  = 1;
                    mt[i]    = 0;
                end else if (m_end) begin
                    mact[i] = 0;
                end else if (mact[i]) begin
                    mt[i]++;
                end
                if (m_push) mq[i][m_tail] = m_din;
                mcnt[i] = m_pre + int'(m_push) - int'(m_pop);
            end
        end
    end

    function automatic logic exp_tx(input int i);
        int k;
        if (!mact[i]) return 1'b1;
        k = mt[i] / cpb[i];
        if (k == 0) return 1'b0;
        if (k <= 8) return mbyte[i][k-1];
        return 1'b1;
    endfunction

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            logic [5:0] act, exp;
            exp = {exp_tx(i), (mact[i] || mcnt[i] != 0), (!rst && mcnt[i] < DEPTH), 3'(mcnt[i])};
            act = (i == 0) ? {tx0, busy0, rdy0, lvl0} : {tx1, busy1, rdy1, lvl1};
            chk($sformatf("cycle_dut%0d_{tx,busy,ready,level}", i), act, exp);
        end
    end

    // Receiver on the slow instance: 53-cycle offset into the start bit, then one sample every 106.
    int         rx_c = -1;
    int         rx_k;
    logic [7:0] rx_sh;
    logic [7:0] rxq [$];

    always @(posedge clock) begin
        if (rst) begin
            rx_c = -1;
        end else if (rx_c < 0) begin
            if (tx0 == 1'b0) rx_c = 0;
        end else begin
            rx_c++;
            if (rx_c == 53 && tx0 != 1'b0) begin
                rx_c = -1;
            end else if (rx_c > 53 && (rx_c - 53) % 106 == 0) begin
                rx_k = (rx_c - 53) / 106;
                if (rx_k <= 8) begin
                    rx_sh[rx_k-1] = tx0;
                end else begin
                    if (tx0) rxq.push_back(rx_sh);
                    rx_c = -1;
                end
            end
        end
    end

    logic [7:0] msg [6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
    int         k, acc;
    logic       last_rdy, saw_low, seen_full_pop, prev_rdy;
    logic [2:0] prev_lvl;
    logic [39:0] cap, exp5;

    initial begin
        // 1: reset and idle
        #1 rst = 1'b1;
        repeat (200) @(posedge clock);
        #2;
        chk("rst_tx", tx0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_in_ready", rdy0, 0);
        chk("rst_level", lvl0, 0);
        rst = 1'b0;
        #1;
        chk("release_in_ready", rdy0, 1);
        repeat (500) tick();
        chk("idle_tx", tx0, 1);
        chk("idle_busy", busy0, 0);
        chk("idle_level", lvl0, 0);

        // 2: single byte 0x55
        v0 = 1'b1; d0 = 8'h55;
        tick();
        v0 = 1'b0;
        tick();
        chk("t2_start_low_after_N+1", tx0, 0);
        k = 1;
        while (busy0 && k < 3000) begin tick(); k++; end
        chk("t2_busy_drop_cycle", k, 1061);
        chk("t2_rx_count", rxq.size(), 1);
        chk("t2_rx_byte", (rxq.size() > 0) ? rxq[0] : -1, 8'h55);
        rxq.delete();

        // 3: burst "Hello!"
        acc = 0;
        for (int j = 0; j < 6; j++) begin
            d0 = msg[j]; v0 = 1'b1;
            last_rdy = rdy0;
            if (rdy0) acc++;
            tick();
        end
        chk("t3_accepted_in_burst", acc, 5);
        chk("t3_ready_on_6th", last_rdy, 0);
        k = 0;
        while (!rdy0 && k < 3000) begin tick(); k++; end
        chk("t3_bang_accepted_in_time", (k > 0 && k < 3000), 1);
        tick();
        v0 = 1'b0;
        k = 0;
        while (rxq.size() < 6 && k < 8000) begin tick(); k++; end
        chk("t3_rx_count", rxq.size(), 6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("t3_rx_byte%0d", j), (j < rxq.size()) ? rxq[j] : -1, msg[j]);
        k = 0;
        while (busy0 && k < 3000) begin tick(); k++; end
        rxq.delete();

        // 4: reset during data bit 3 of 0xA3 with two bytes queued
        v0 = 1'b1; d0 = 8'hA3; tick();
        d0 = 8'h11; tick();
        d0 = 8'h22; tick();
        v0 = 1'b0;
        chk("t4_queued_level", lvl0, 2);
        repeat (470) tick();
        rst = 1'b1;
        #1;
        chk("t4_rst_tx", tx0, 1);
        chk("t4_rst_level", lvl0, 0);
        chk("t4_rst_busy", busy0, 0);
        repeat (3) tick();
        rst = 1'b0;
        saw_low = 1'b0;
        repeat (1500) begin tick(); if (!tx0) saw_low = 1'b1; end
        chk("t4_no_frame_after_release", saw_low, 0);
        chk("t4_rx_nothing", rxq.size(), 0);

        // 5: two-clock bit period, 0x00 then 0xFF
        v1 = 1'b1; d1 = 8'h00; tick();
        d1 = 8'hFF; tick();
        v1 = 1'b0;
        for (int j = 0; j < 40; j++) begin
            cap[j] = tx1;
            exp5[j] = (j < 18) ? 1'b0 : (j < 20) ? 1'b1 : (j < 22) ? 1'b0 : 1'b1;
            tick();
        end
        chk("t5_waveform", cap, exp5);
        chk("t5_idle_after", busy1, 0);

        // 6: push held while full, pop on the same edge
        seen_full_pop = 1'b0;
        for (int j = 0; j < 7; j++) begin
            v1 = 1'b1; d1 = 8'hC0 + 8'(j);
            k = 0;
            do begin
                prev_rdy = rdy1; prev_lvl = lvl1;
                tick(); k++;
                if (prev_lvl == 3'd4 && lvl1 == 3'd3 && !prev_rdy) seen_full_pop = 1'b1;
            end while (!prev_rdy && k < 200);
        end
        v1 = 1'b0;
        chk("t6_full_refused_with_pop", seen_full_pop, 1);
        k = 0;
        while (busy1 && k < 1000) begin tick(); k++; end
        chk("t6_drain", busy1, 0);

        // random traffic on both instances
        for (int n = 0; n < 25000; n++) begin
            v0 = ($urandom_range(0, 299) == 0); d0 = 8'($urandom);
            v1 = ($urandom_range(0, 5) == 0);   d1 = 8'($urandom);
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        k = 0;
        while ((busy0 || busy1) && k < 8000) begin tick(); k++; end
        chk("final_idle", {busy0, busy1, tx0, tx1}, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
